// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and NOP-bubble control masking.
module id_ex_skid_stage #(
   parameter int PAYLOAD_W = 275,
   parameter int CTRL_W    = 8,
   parameter bit SKID_EN   = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [CTRL_W-1:0]    in_ctrl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_cnt
);

   // Handshake: a beat moves when valid & ready are both high at a rising edge;
   // valid never waits on ready, and a held beat stays bit-stable until taken.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PAYLOAD_W-1:0]   main_payload_q, main_payload_d;
   logic [CTRL_W-1:0]      main_ctrl_q, main_ctrl_d;
   logic [PAYLOAD_W-1:0]   skid_payload_q, skid_payload_d;
   logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
   logic                   in_xfer, out_xfer;

   assign out_valid   = (state_q != EMPTY);
   assign in_ready    = SKID_EN ? (state_q != SKID) : (!out_valid || out_ready);
   assign in_xfer     = in_valid && in_ready;
   assign out_xfer    = out_valid && out_ready;
   assign out_payload = main_payload_q;
   assign out_ctrl    = out_valid ? main_ctrl_q : '0;
   assign occupancy   = state_q;

   always_comb begin
      state_d        = state_q;
      main_payload_d = main_payload_q;
      main_ctrl_d    = main_ctrl_q;
      skid_payload_d = skid_payload_q;
      skid_ctrl_d    = skid_ctrl_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d        = FULL;
               main_payload_d = in_payload;
               main_ctrl_d    = in_ctrl;
            end
         end
         FULL: begin
            if (in_xfer && out_xfer) begin
               main_payload_d = in_payload;
               main_ctrl_d    = in_ctrl;
            end else if (in_xfer && SKID_EN) begin
               // Head is stalled: park the new beat behind it.
               state_d        = SKID;
               skid_payload_d = in_payload;
               skid_ctrl_d    = in_ctrl;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         SKID: begin
            if (out_xfer) begin
               state_d        = FULL;
               main_payload_d = skid_payload_q;
               main_ctrl_d    = skid_ctrl_q;
               skid_payload_d = '0;
               skid_ctrl_d    = '0;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush overrides any handshake and drops a beat offered this cycle.
      if (flush) begin
         state_d        = EMPTY;
         main_payload_d = '0;
         main_ctrl_d    = '0;
         skid_payload_d = '0;
         skid_ctrl_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= EMPTY;
         main_payload_q <= '0;
         main_ctrl_q    <= '0;
         skid_payload_q <= '0;
         skid_ctrl_q    <= '0;
      end else begin
         state_q        <= state_d;
         main_payload_q <= main_payload_d;
         main_ctrl_q    <= main_ctrl_d;
         skid_payload_q <= skid_payload_d;
         skid_ctrl_q    <= skid_ctrl_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: default skid build, SKID_EN=0 build and
// a CNT_W=2 build share one stimulus stream; each test checks the relevant one.
module tb_id_ex_skid_stage;

   localparam int PW = 275;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [PW-1:0] in_payload = '0;
   logic [CW-1:0] in_ctrl = '0;

   logic          in_ready, out_valid;
   logic [PW-1:0] out_payload;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [15:0]   stall_cnt;

   logic          n_in_ready, n_out_valid;
   logic [PW-1:0] n_out_payload;
   logic [CW-1:0] n_out_ctrl;
   logic [1:0]    n_occupancy;
   logic [15:0]   n_stall_cnt;

   logic          s_in_ready, s_out_valid;
   logic [PW-1:0] s_out_payload;
   logic [CW-1:0] s_out_ctrl;
   logic [1:0]    s_occupancy;
   logic [1:0]    s_stall_cnt;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   id_ex_skid_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_payload(in_payload), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_payload(out_payload), .out_ctrl(out_ctrl),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   id_ex_skid_stage #(.SKID_EN(1'b0)) dut_noskid (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready),
      .in_payload(in_payload), .in_ctrl(in_ctrl),
      .out_valid(n_out_valid), .out_ready(out_ready),
      .out_payload(n_out_payload), .out_ctrl(n_out_ctrl),
      .occupancy(n_occupancy), .stall_cnt(n_stall_cnt)
   );

   id_ex_skid_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_payload(in_payload), .in_ctrl(in_ctrl),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_payload(s_out_payload), .out_ctrl(s_out_ctrl),
      .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
   );

   function automatic logic [PW-1:0] mk_pay(input int k);
      logic [PW-1:0] v;
      v = (PW'(k) << 260) | (PW'(k * 7 + 3) << 100) | PW'(k);
      return v;
   endfunction

   function automatic logic [CW-1:0] mk_ctrl(input int k);
      return CW'(k * 17 + 1);
   endfunction

   task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int k);
      in_valid   = 1'b1;
      in_payload = mk_pay(k);
      in_ctrl    = mk_ctrl(k);
   endtask

   initial begin
      // Reset values while rst is held
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_payload", out_payload, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Stream 4 beats with out_ready high
      out_ready = 1'b1;
      offer(1);
      #1;
      check("stream_not_yet_valid", out_valid, 0);
      for (int k = 1; k <= 4; k++) begin
         offer(k);
         step();
         check($sformatf("stream_valid_%0d", k), out_valid, 1);
         check($sformatf("stream_pay_%0d", k), out_payload, mk_pay(k));
         check($sformatf("stream_ctrl_%0d", k), out_ctrl, mk_ctrl(k));
         check($sformatf("stream_occ_%0d", k), occupancy, 1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", out_valid, 0);
      check("stream_stall_cnt", stall_cnt, 0);

      // Skid fill under back-pressure
      out_ready = 1'b0;
      offer(10);
      step();
      check("skid_a_in_ready", in_ready, 1);
      offer(11);
      step();
      check("skid_occ2", occupancy, 2);
      check("skid_in_ready_low", in_ready, 0);
      check("skid_head_a", out_payload, mk_pay(10));
      in_valid = 1'b0;
      step();
      step();
      check("skid_stall_3", stall_cnt, 3);
      check("skid_head_stable", out_payload, mk_pay(10));
      check("skid_ctrl_stable", out_ctrl, mk_ctrl(10));
      out_ready = 1'b1;
      step();
      check("drain_stall_hold", stall_cnt, 3);
      check("drain_head_b", out_payload, mk_pay(11));
      check("drain_ctrl_b", out_ctrl, mk_ctrl(11));
      check("drain_occ1", occupancy, 1);
      check("drain_in_ready_back", in_ready, 1);
      step();
      check("drain_empty", out_valid, 0);

      // Flush while in SKID with a beat offered
      out_ready = 1'b0;
      offer(20);
      step();
      offer(21);
      step();
      check("flush_pre_occ2", occupancy, 2);
      offer(30);
      flush = 1'b1;
      step();
      check("flush_occ0", occupancy, 0);
      check("flush_out_valid", out_valid, 0);
      check("flush_out_ctrl", out_ctrl, 0);
      check("flush_out_payload", out_payload, 0);
      check("flush_stall_kept", stall_cnt, 5);
      check("sat_stall_cnt", s_stall_cnt, 3);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("flush_beat_dropped", out_valid, 0);

      // Bubble: ctrl offered without valid
      in_ctrl = 8'hFF;
      in_payload = mk_pay(33);
      step();
      check("bubble_ctrl", out_ctrl, 0);
      check("bubble_valid", out_valid, 0);

      // Asynchronous reset between edges
      out_ready = 1'b0;
      offer(40);
      step();
      check("arst_pre_valid", out_valid, 1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_payload", out_payload, 0);
      check("arst_out_ctrl", out_ctrl, 0);
      check("arst_occupancy", occupancy, 0);
      check("arst_stall_cnt", stall_cnt, 0);
      check("arst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      step();

      // SKID_EN=0 build: combinational in_ready, occupancy capped at 1
      out_ready = 1'b0;
      offer(50);
      #1;
      check("noskid_ready_empty", n_in_ready, 1);
      step();
      check("noskid_ready_full_stalled", n_in_ready, 0);
      check("noskid_occ1", n_occupancy, 1);
      offer(51);
      step();
      check("noskid_occ_capped", n_occupancy, 1);
      check("noskid_head_held", n_out_payload, mk_pay(50));
      out_ready = 1'b1;
      #1;
      check("noskid_ready_follows", n_in_ready, 1);
      step();
      check("noskid_head_b", n_out_payload, mk_pay(51));
      check("noskid_ctrl_b", n_out_ctrl, mk_ctrl(51));
      check("noskid_occ_b", n_occupancy, 1);
      in_valid = 1'b0;
      step();
      check("noskid_empty", n_occupancy, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
